// File: rtl/data_memory_ctrl.sv
// MIPS data memory controller: req/resp handshake, programmable wait states,
// byte/half/word access with load sign extension and alignment checking.
module dmem_lane #(
    parameter int IDX_W = 8
) (
    input  logic             Clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [2**IDX_W];

    always_ff @(posedge Clk)
        if (we) mem[idx] <= wdata;

    assign rdata = mem[idx];
endmodule

module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic              We,
    input  logic [1:0]        Size,
    input  logic              Sign_ext,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Data_in,
    output logic              Ready,
    output logic              Valid,
    output logic [31:0]       Data_out,
    output logic              Misalign
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             we_q, sx_q;
    logic [1:0]       size_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      din_q;

    logic             illegal, commit;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lane_mask;
    logic [31:0]      wdata, rd_word, rd_shift, load_val;
    logic [15:0]      rd_half;

    // Upper address bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[ADDR_W-1:IDX_W+2];

    assign illegal = (Size == 2'b11) ||
                     (Size == 2'b01 && Addr[0]) ||
                     (Size == 2'b10 && Addr[1:0] != 2'b00);

    assign off = addr_q[1:0];
    assign idx = addr_q[IDX_W+1:2];
    // Reset at the commit edge must suppress the write.
    assign commit = (state == S_WAIT) && (cnt == 4'd0) && !Rst;

    always_comb begin
        lane_mask = 4'b1111;
        wdata     = din_q;
        case (size_q)
            2'b00: begin
                lane_mask = 4'b0001 << off;
                wdata     = {4{din_q[7:0]}};
            end
            2'b01: begin
                lane_mask = off[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{din_q[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dmem_lane #(.IDX_W(IDX_W)) u_lane (
            .Clk   (Clk),
            .we    (commit && we_q && lane_mask[k]),
            .idx   (idx),
            .wdata (wdata[8*k +: 8]),
            .rdata (rd_word[8*k +: 8])
        );
    end

    assign rd_shift = rd_word >> {off, 3'b000};
    assign rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{sx_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{sx_q & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            Ready    <= 1'b1;
            Valid    <= 1'b0;
            Misalign <= 1'b0;
            Data_out <= 32'd0;
            we_q     <= 1'b0;
            sx_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            din_q    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    Valid    <= 1'b0;
                    Misalign <= 1'b0;
                    if (Req) begin
                        we_q   <= We;
                        sx_q   <= Sign_ext;
                        size_q <= Size;
                        addr_q <= Addr[IDX_W+1:0];
                        din_q  <= Data_in;
                        Ready  <= 1'b0;
                        if (illegal) begin
                            state    <= S_RESP;
                            Valid    <= 1'b1;
                            Misalign <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= S_RESP;
                        Valid    <= 1'b1;
                        Misalign <= 1'b0;
                        if (!we_q) Data_out <= load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    Valid    <= 1'b0;
                    Misalign <= 1'b0;
                    Ready    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: instance 0 has WAIT_CYCLES=2, instance 1 has WAIT_CYCLES=0.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic        we, sx;
    logic [1:0]  size;
    logic [31:0] addr, din;
    logic [1:0]  rdy, vld, mis;
    logic [31:0] dout [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Rst(rst), .Req(req[0]), .We(we), .Size(size), .Sign_ext(sx),
        .Addr(addr), .Data_in(din), .Ready(rdy[0]), .Valid(vld[0]),
        .Data_out(dout[0]), .Misalign(mis[0]));

    data_memory_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Rst(rst), .Req(req[1]), .We(we), .Size(size), .Sign_ext(sx),
        .Addr(addr), .Data_in(din), .Ready(rdy[1]), .Valid(vld[1]),
        .Data_out(dout[1]), .Misalign(mis[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one access on instance u, checks accept, latency and Misalign,
    // and returns one cycle after Valid with the block back in IDLE.
    task automatic access(input int u, input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic exp_mis, input string tag);
        int k;
        chk({tag, "_ready"}, 32'(rdy[u]), 32'd1);
        req[u] = 1'b1; we = w; size = sz; sx = s; addr = a; din = d;
        @(posedge clk); #1;
        req[u] = 1'b0;
        k = 0;
        while (!vld[u] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, 32'(k + 1), 32'(exp_lat));
        chk({tag, "_misalign"}, 32'(mis[u]), 32'(exp_mis));
        @(posedge clk); #1;
    endtask

    initial begin
        int c, v1, v2;
        rst = 1'b1; req = 2'b00; we = 1'b0; size = 2'b00; sx = 1'b0; addr = 32'd0; din = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_misalign", 32'(mis[0]), 32'd0);
        chk("rst_dout", dout[0], 32'd0);
        chk("rst_dout_w0", dout[1], 32'd0);

        // word store/load
        access(0, 1, 2'b10, 0, 32'h0, 32'h12345678, 4, 0, "sw0");
        access(0, 0, 2'b10, 0, 32'h0, 32'h0, 4, 0, "lw0");
        chk("lw0_data", dout[0], 32'h12345678);

        // byte store and byte loads
        access(0, 1, 2'b00, 0, 32'h1, 32'hFFFFFFAB, 4, 0, "sb1");
        access(0, 0, 2'b10, 0, 32'h0, 32'h0, 4, 0, "lw0b");
        chk("lw0b_data", dout[0], 32'h1234AB78);
        access(0, 0, 2'b00, 1, 32'h1, 32'h0, 4, 0, "lb1");
        chk("lb1_data", dout[0], 32'hFFFFFFAB);
        access(0, 0, 2'b00, 0, 32'h1, 32'h0, 4, 0, "lbu1");
        chk("lbu1_data", dout[0], 32'h000000AB);

        // half store and loads
        access(0, 1, 2'b10, 0, 32'h4, 32'h55667788, 4, 0, "sw4");
        access(0, 1, 2'b01, 0, 32'h6, 32'h12348001, 4, 0, "sh6");
        access(0, 0, 2'b01, 1, 32'h6, 32'h0, 4, 0, "lh6");
        chk("lh6_data", dout[0], 32'hFFFF8001);
        access(0, 0, 2'b10, 0, 32'h4, 32'h0, 4, 0, "lw4");
        chk("lw4_data", dout[0], 32'h80017788);

        // illegal accesses: fast response, no side effects
        access(0, 0, 2'b10, 0, 32'h2, 32'h0, 1, 1, "lw2_bad");
        chk("lw2_bad_dout", dout[0], 32'h80017788);
        access(0, 1, 2'b01, 0, 32'h3, 32'h0, 1, 1, "sh3_bad");
        access(0, 1, 2'b11, 0, 32'h0, 32'h0, 1, 1, "sz11_bad");
        access(0, 0, 2'b10, 0, 32'h0, 32'h0, 4, 0, "lw0c");
        chk("lw0c_data", dout[0], 32'h1234AB78);

        // address aliasing modulo 1 KiB
        access(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 4, 0, "sw400");
        access(0, 0, 2'b10, 0, 32'h0, 32'h0, 4, 0, "lw0d");
        chk("alias_data", dout[0], 32'hCAFEF00D);
        access(0, 0, 2'b01, 1, 32'h2, 32'h0, 4, 0, "lh2");
        chk("lh2_data", dout[0], 32'hFFFFCAFE);
        access(0, 0, 2'b00, 1, 32'h0, 32'h0, 4, 0, "lb0");
        chk("lb0_data", dout[0], 32'h0000000D);

        // reset during WAIT abandons the store
        access(0, 1, 2'b10, 0, 32'h8, 32'h11111111, 4, 0, "sw8");
        req[0] = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h8; din = 32'hDEADBEEF;
        @(posedge clk); #1;
        req[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwait_valid", 32'(vld[0]), 32'd0);
        chk("rstwait_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        chk("rstwait_valid2", 32'(vld[0]), 32'd0);
        // reset landing exactly on the commit edge
        req[0] = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h8; din = 32'h22222222;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstcommit_valid", 32'(vld[0]), 32'd0);
        chk("rstcommit_ready", 32'(rdy[0]), 32'd1);
        access(0, 0, 2'b10, 0, 32'h8, 32'h0, 4, 0, "lw8");
        chk("lw8_data", dout[0], 32'h11111111);

        // WAIT_CYCLES=0 instance
        access(1, 1, 2'b10, 0, 32'h10, 32'hA5A5A5A5, 2, 0, "w0_sw");
        req[1] = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
        v1 = -1; v2 = -1;
        for (c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (vld[1]) begin
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
            end
        end
        req[1] = 1'b0;
        chk("w0_first_valid", 32'(v1), 32'd2);
        chk("w0_spacing", 32'(v2 - v1), 32'd3);
        chk("w0_lw_data", dout[1], 32'hA5A5A5A5);
        repeat (3) @(posedge clk);
        #1;
        req[1] = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; din = 32'h5A5A5A5A;
        @(posedge clk); #1;
        req[1] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("w0_rst_valid", 32'(vld[1]), 32'd0);
        chk("w0_rst_ready", 32'(rdy[1]), 32'd1);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 2, 0, "w0_lw");
        chk("w0_rst_data", dout[1], 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
